// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serial frame transmitter packing its bitstream into checkerboard-ordered odd/even bank memories
module sti_dac_gen #(
  parameter int DATA_W = 16,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W = 5,
  parameter int CHK_BIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  output logic                 pi_ready,
  input  logic [DATA_W-1:0]    pi_data,
  input  logic [1:0]           pi_length,
  input  logic                 pi_fill,
  input  logic                 pi_msb,
  input  logic                 pi_low,
  input  logic                 pi_end,
  output logic                 so_data,
  output logic                 so_valid,
  output logic [7:0]           oem_dataout,
  output logic [ADDR_W-1:0]    oem_addr,
  output logic [NUM_BANKS-1:0] odd_wr,
  output logic [NUM_BANKS-1:0] even_wr,
  output logic                 oem_finish,
  output logic                 overflow
);
  localparam int TOTAL = 2 * NUM_BANKS * (1 << ADDR_W);
  localparam int BW = $clog2(TOTAL) + 1;
  typedef enum logic [2:0] {IDLE, PREP, SHIFT, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0] len_q, len_d;
  logic fill_q, fill_d, msb_q, msb_d, low_q, low_d;
  logic [31:0] frame_q, frame_d, raw, rev;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, dout_q, dout_d;
  logic [BW-1:0] b_q, b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_BANKS-1:0] odd_q, odd_d, even_q, even_d, bank_oh;
  logic finish_q, finish_d, ovf_q, ovf_d;
  logic full, last, wr, par, take;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      len_q    <= '0;
      fill_q   <= 1'b0;
      msb_q    <= 1'b0;
      low_q    <= 1'b0;
      frame_q  <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      dout_q   <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      odd_q    <= '0;
      even_q   <= '0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      msb_q    <= msb_d;
      low_q    <= low_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      dout_q   <= dout_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      odd_q    <= odd_d;
      even_q   <= even_d;
      finish_q <= finish_d;
      ovf_q    <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load ? PREP : pi_end ? (full ? DONE : FLUSH) : IDLE;
      PREP:    state_d = SHIFT;
      SHIFT:   state_d = cnt_q == 5'd0 ? IDLE : SHIFT;
      FLUSH:   state_d = last ? DONE : FLUSH;
      default: state_d = DONE;
    endcase
  end
  always_comb begin
    pi_ready = state_q == IDLE;
    so_valid = state_q == SHIFT;
    so_data  = so_valid & frame_q[cnt_q];
  end
  always_comb begin
    take = state_q == IDLE && load;
    data_d = take ? pi_data : data_q;
    len_d  = take ? pi_length : len_q;
    fill_d = take ? pi_fill : fill_q;
    msb_d  = take ? pi_msb : msb_q;
    low_d  = take ? pi_low : low_q;
    full = b_q == BW'(TOTAL);
    last = b_q == BW'(TOTAL - 1);
    raw = len_q == 2'd0 ? {24'h0, low_q ? data_q[15:8] : data_q[7:0]}
        : len_q == 2'd1 ? {16'h0, data_q}
        : len_q == 2'd2 ? (fill_q ? {8'h0, data_q, 8'h0} : {16'h0, data_q})
        : (fill_q ? {data_q, 16'h0} : {16'h0, data_q});
    rev = {<<{raw}};
    frame_d = state_q != PREP ? frame_q : msb_q ? raw : rev >> (5'd24 - {len_q, 3'b000});
    cnt_d = state_q == PREP ? {len_q, 3'b111} : state_q == SHIFT ? cnt_q - 5'd1 : cnt_q;
    byte_d = state_q == SHIFT ? {byte_q[6:0], so_data} : byte_q;
    wr = (state_q == SHIFT && cnt_q[2:0] == 3'd0) || state_q == FLUSH;
    par = b_q[0] ^ b_q[CHK_BIT + 1];
    bank_oh = NUM_BANKS'(1) << (b_q >> (ADDR_W + 1));
    odd_d  = wr && !full && !par ? bank_oh : '0;
    even_d = wr && !full && par ? bank_oh : '0;
    dout_d = wr && !full ? (state_q == FLUSH ? 8'h00 : {byte_q[6:0], so_data}) : dout_q;
    addr_d = wr && !full ? b_q[ADDR_W:1] : addr_q;
    b_d    = wr && !full ? b_q + BW'(1) : b_q;
    ovf_d  = ovf_q | (wr & full);
    finish_d = state_q == DONE;
  end
  assign odd_wr      = odd_q & {NUM_BANKS{reset}};
  assign even_wr     = even_q & {NUM_BANKS{reset}};
  assign oem_dataout = dout_q;
  assign oem_addr    = addr_q;
  assign oem_finish  = finish_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_sti_dac_gen.sv
// tb_sti_dac_gen: directed and random frames checked against a byte-stream placement model
module tb_sti_dac_gen;
  localparam int NB = 4;
  localparam int AW = 5;
  localparam int CHK = 2;
  localparam int DEPTH = 1 << AW;
  localparam int TOTAL = 2 * NB * DEPTH;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic pi_ready;
  logic [15:0] pi_data = '0;
  logic [1:0] pi_length = '0;
  logic pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
  logic so_data, so_valid;
  logic [7:0] oem_dataout;
  logic [AW-1:0] oem_addr;
  logic [NB-1:0] odd_wr, even_wr;
  logic oem_finish, overflow;
  int n_assert = 0;
  int n_fail = 0;
  int nb = 0;
  bit ovf_exp = 0;
  sti_dac_gen #(.DATA_W(16), .NUM_BANKS(NB), .ADDR_W(AW), .CHK_BIT(CHK)) dut (
    .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
    .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_so"}, {so_valid, so_data}, 0);
    chk({tag, "_wr"}, {odd_wr, even_wr}, 0);
    chk({tag, "_dout"}, oem_dataout, 0);
    chk({tag, "_addr"}, oem_addr, 0);
    chk({tag, "_fin_ovf"}, {oem_finish, overflow}, 0);
  endtask
  task automatic expect_none(input string tag);
    chk(tag, {odd_wr, even_wr}, 0);
  endtask
  task automatic expect_byte(input logic [7:0] exp);
    int bank, addr;
    logic [NB-1:0] ov, ev;
    if (nb >= TOTAL) begin
      ovf_exp = 1;
      chk("no_wr_when_full", {odd_wr, even_wr}, 0);
      return;
    end
    bank = nb / (2 * DEPTH);
    addr = (nb / 2) % DEPTH;
    ov = '0;
    ev = '0;
    if (((nb % 2) ^ ((addr >> CHK) & 1)) == 1) ev[bank] = 1'b1;
    else ov[bank] = 1'b1;
    chk("odd_wr", odd_wr, ov);
    chk("even_wr", even_wr, ev);
    chk("oem_addr", oem_addr, addr);
    chk("oem_dataout", oem_dataout, exp);
    nb++;
  endtask
  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic msb,
                      input logic low, input int abort_at);
    logic [31:0] v;
    logic [7:0] bytes[4];
    bit q[$];
    int L;
    L = 8 * (int'(len) + 1);
    v = len == 2'd0 ? 32'(low ? d[15:8] : d[7:0]) : len == 2'd1 ? 32'(d)
      : len == 2'd2 ? (fill ? 32'({d, 8'h00}) : 32'(d)) : (fill ? {d, 16'h0000} : 32'(d));
    for (int i = 0; i < L; i++) q.push_back(msb ? v[L - 1 - i] : v[i]);
    for (int j = 0; j < L / 8; j++) begin
      bytes[j] = 8'h00;
      for (int i = 0; i < 8; i++) bytes[j] = {bytes[j][6:0], q[8 * j + i]};
    end
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; load = 1'b1;
    tick();
    load = 1'b0;
    chk("prep_idle_out", {so_valid, pi_ready}, 0);
    expect_none("prep_no_wr");
    for (int k = 0; k < L; k++) begin
      tick();
      chk("so_valid", so_valid, 1);
      chk("so_data", so_data, q[k]);
      if (k >= 8 && k % 8 == 0) expect_byte(bytes[k / 8 - 1]);
      else expect_none("shift_no_wr");
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        expect_none("no_wr_in_reset");
        tick();
        chk_zero("abort");
        return;
      end
    end
    tick();
    chk("after_so_valid", {so_valid, so_data}, 0);
    chk("after_ready", pi_ready, 1);
    expect_byte(bytes[L / 8 - 1]);
    chk("overflow", overflow, ovf_exp);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();
    chk("ready_after_reset", pi_ready, 1);
    chk_zero("idle");
    nb = 0;
    ovf_exp = 0;
  endtask
  initial begin
    do_reset();
    send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, -1);
    send(16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, -1);
    send(16'hBEEF, 2'd2, 1'b1, 1'b1, 1'b0, -1);
    send(16'hBEEF, 2'd3, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    send(16'h5A3C, 2'd1, 1'b0, 1'b1, 1'b0, 5);
    tick();
    reset = 1'b1;
    tick();
    chk("ready_after_abort", pi_ready, 1);
    chk_zero("post_abort");
    nb = 0;
    ovf_exp = 0;
    send(16'($urandom), 2'd1, 1'($urandom), 1'($urandom), 1'b0, -1);
    send(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), -1);
    pi_end = 1'b1;
    tick();
    pi_end = 1'b0;
    expect_none("flush_first_no_wr");
    while (nb < TOTAL) begin
      tick();
      expect_byte(8'h00);
      chk("finish_low_in_flush", oem_finish, 0);
    end
    tick();
    chk("finish_high", oem_finish, 1);
    chk("done_not_ready", pi_ready, 0);
    expect_none("done_no_wr");
    pi_data = 16'hFFFF; pi_length = 2'd0; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_ignores_load", {so_valid, pi_ready, oem_finish}, 3'b001);
      expect_none("done_load_no_wr");
    end
    load = 1'b0;
    do_reset();
    for (int i = 0; i < TOTAL / 4; i++)
      send(16'($urandom), 2'd3, 1'($urandom), 1'($urandom), 1'b0, -1);
    chk("no_overflow_yet", overflow, 0);
    send(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), -1);
    chk("overflow_set", overflow, 1);
    pi_end = 1'b1;
    tick();
    pi_end = 1'b0;
    expect_none("full_end_no_wr");
    chk("full_end_finish_lag", oem_finish, 0);
    tick();
    chk("full_end_finish", {oem_finish, overflow, pi_ready}, 3'b110);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
